// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and the DataPath.
// Holds the default word/address widths, the responder FSM encoding and a
// small helper that flags MAR values above the implemented address range.
package mem_pkg;

    localparam int MEM_ADDR_W = 9;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } mem_state_t;

    // True when any MAR bit above the implemented word-address bits is set.
    function automatic logic addr_out_of_range(input logic [31:0] mar_val, input int addr_w);
        return (mar_val >> addr_w) != 32'd0;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, no reset (contents survive clear).
// Ports: clk, we (write enable), addr (word address), din (write data),
//        dout (registered read of addr, read-before-write on the same edge).
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] dout_r;

    // Array write and registered read of the presented address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
        dout_r <= mem_r[addr];
    end

    assign dout = dout_r;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface.
// Accepts level memread/memwrite strobes from IDLE, inserts WAIT_CYCLES wait
// states, performs one array access, then holds mem_ready in DONE until both
// strobes drop. initMem preloads the array while IDLE.
// Ports: clock, clear (sync reset), mar, wr_data, memread, memwrite,
//        mem_data, mem_ready, busy, err, initMem, init_addr, init_data.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [31:0]       mar,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              memread,
    input  logic              memwrite,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              busy,
    output logic              err,
    input  logic              initMem,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    mem_state_t        state_r, next_state_s;
    logic [3:0]        cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic              oor_r;
    logic [DATA_W-1:0] wdata_r;
    logic              is_write_r;
    logic [DATA_W-1:0] mem_data_r, mem_data_next_s;
    logic              ready_r, ready_next_s;
    logic              busy_r;
    logic              err_r, err_next_s;
    logic              accept_s;
    logic              lat_strobe_s;
    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_din_s;
    logic [DATA_W-1:0] ram_dout_s;

    // The array read is registered, so the access address is presented one
    // cycle ahead: in IDLE the live MAR feeds the array, so the edge that
    // enters ACCESS (from IDLE or WAIT) has already captured RAM[addr].
    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk  (clock),
        .we   (ram_we_s & ~clear),
        .addr (ram_addr_s),
        .din  (ram_din_s),
        .dout (ram_dout_s)
    );

    // Next-state, array port mux and next values of the registered outputs.
    always_comb begin
        next_state_s    = state_r;
        accept_s        = 1'b0;
        ram_we_s        = 1'b0;
        ram_addr_s      = addr_r;
        ram_din_s       = wdata_r;
        mem_data_next_s = mem_data_r;
        ready_next_s    = 1'b0;
        err_next_s      = 1'b0;
        lat_strobe_s    = is_write_r ? memwrite : memread;

        case (state_r)
            ST_IDLE: begin
                ram_addr_s = mar[ADDR_W-1:0];
                if (initMem) begin
                    ram_we_s   = 1'b1;
                    ram_addr_s = init_addr;
                    ram_din_s  = init_data;
                end else if (memread && memwrite) begin
                    err_next_s = 1'b1;
                end else if (memread || memwrite) begin
                    accept_s     = 1'b1;
                    next_state_s = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!lat_strobe_s) begin
                    next_state_s = ST_IDLE;
                end else if (cnt_r <= 4'd1) begin
                    next_state_s = ST_ACCESS;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_ACCESS: begin
                next_state_s = ST_DONE;
                ready_next_s = 1'b1;
                if (oor_r) begin
                    err_next_s = 1'b1;
                    if (!is_write_r) begin
                        mem_data_next_s = '0;
                    end else begin
                        mem_data_next_s = mem_data_r;
                    end
                end else if (is_write_r) begin
                    ram_we_s = 1'b1;
                end else begin
                    mem_data_next_s = ram_dout_s;
                end
            end
            ST_DONE: begin
                if (!memread && !memwrite) begin
                    next_state_s = ST_IDLE;
                end else begin
                    ready_next_s = lat_strobe_s;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, request latches, wait counter and registered outputs.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            addr_r     <= '0;
            oor_r      <= 1'b0;
            wdata_r    <= '0;
            is_write_r <= 1'b0;
            mem_data_r <= '0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            mem_data_r <= mem_data_next_s;
            ready_r    <= ready_next_s;
            busy_r     <= (next_state_s != ST_IDLE);
            err_r      <= err_next_s;
            if (accept_s) begin
                addr_r     <= mar[ADDR_W-1:0];
                oor_r      <= addr_out_of_range(mar, ADDR_W);
                wdata_r    <= wr_data;
                is_write_r <= memwrite;
                cnt_r      <= WAIT_INIT;
            end else if (state_r == ST_WAIT) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign mem_data  = mem_data_r;
    assign mem_ready = ready_r;
    assign busy      = busy_r;
    assign err       = err_r;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        clear;
    logic [31:0] mar, wr_data, mem_data, init_data;
    logic        memread, memwrite, mem_ready, busy, err, initMem;
    logic [8:0]  init_addr;

    logic [31:0] mar0, wr_data0, mem_data0, init_data0;
    logic        memread0, memwrite0, mem_ready0, busy0, err0, initMem0;
    logic [8:0]  init_addr0;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [512];
    logic [31:0] exp_md;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(1)) dut (
        .clock(clk), .clear(clear), .mar(mar), .wr_data(wr_data),
        .memread(memread), .memwrite(memwrite), .mem_data(mem_data),
        .mem_ready(mem_ready), .busy(busy), .err(err), .initMem(initMem),
        .init_addr(init_addr), .init_data(init_data)
    );

    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .clock(clk), .clear(clear), .mar(mar0), .wr_data(wr_data0),
        .memread(memread0), .memwrite(memwrite0), .mem_data(mem_data0),
        .mem_ready(mem_ready0), .busy(busy0), .err(err0), .initMem(initMem0),
        .init_addr(init_addr0), .init_data(init_data0)
    );

    // Drives one request, holds the strobe `hold` cycles past the first ready,
    // then drops it; reports what was observed over a fixed 20-cycle window.
    task automatic run_access(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                              input int hold, output int lat, output logic [31:0] rdata,
                              output int busy_cnt, output int err_cnt, output int ready_cnt);
        bit seen;
        int after;
        lat = -1; rdata = '0; busy_cnt = 0; err_cnt = 0; ready_cnt = 0; seen = 1'b0; after = 0;
        mar = addr; wr_data = data; memread = !is_wr; memwrite = is_wr;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (err) err_cnt++;
            if (mem_ready) ready_cnt++;
            if (mem_ready && !seen) begin seen = 1'b1; lat = k - 1; rdata = mem_data; end
            if (seen) begin
                if (after == hold) begin memread = 1'b0; memwrite = 1'b0; end
                after++;
            end
        end
        memread = 1'b0; memwrite = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic preload(input logic [8:0] a, input logic [31:0] d);
        initMem = 1'b1; init_addr = a; init_data = d;
        @(posedge clk); #1;
        initMem = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_data !== 32'h0) begin errors++; $display("FAIL reset_mem_data got %h want 0", mem_data); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", mem_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        clear = 1'b0;
        exp_md = 32'h0;
    endtask

    task automatic test_preload();
        int lat, bc, ec, rc;
        logic [31:0] rd;
        // Strobe raised together with initMem must be ignored.
        mar = 32'd341; memread = 1'b1;
        preload(9'd341, 32'h0A80_0004);
        memread = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL preload_ignores_strobe busy %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL preload_no_err err %b want 0", err); end
        preload(9'd5, 32'h5555_0005);
        preload(9'd30, 32'h3030_3030);
        for (int i = 0; i < 16; i++) preload(9'(100 + i * 7), $urandom());
        run_access(1'b0, 32'd341, 32'h0, 0, lat, rd, bc, ec, rc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL preload_latency got %0d want 2", lat); end
        checks++; if (rd !== 32'h0A80_0004) begin errors++; $display("FAIL preload_data got %h want 0a800004", rd); end
        exp_md = 32'h0A80_0004;
    endtask

    task automatic test_write_read();
        int lat, bc, ec, rc;
        logic [31:0] rd;
        run_access(1'b1, 32'd20, 32'hDEAD_BEEF, 0, lat, rd, bc, ec, rc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL write_latency got %0d want 2", lat); end
        checks++; if (bc !== 3) begin errors++; $display("FAIL write_busy_cycles got %0d want 3", bc); end
        checks++; if (rd !== exp_md) begin errors++; $display("FAIL write_keeps_mem_data got %h want %h", rd, exp_md); end
        checks++; if (ec !== 0) begin errors++; $display("FAIL write_no_err got %0d want 0", ec); end
        model_mem[20] = 32'hDEAD_BEEF;
        run_access(1'b0, 32'd20, 32'h0, 0, lat, rd, bc, ec, rc);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_back got %h want deadbeef", rd); end
        checks++; if (bc !== 3) begin errors++; $display("FAIL read_busy_cycles got %0d want 3", bc); end
        exp_md = 32'hDEAD_BEEF;
    endtask

    task automatic test_hold_abort();
        int lat, bc, ec, rc;
        logic [31:0] rd;
        // memread held for 5 sampled edges: single access, ready until drop.
        run_access(1'b0, 32'd5, 32'h0, 2, lat, rd, bc, ec, rc);
        checks++; if (rc !== 3) begin errors++; $display("FAIL hold_ready_cycles got %0d want 3", rc); end
        checks++; if (bc !== 5) begin errors++; $display("FAIL hold_busy_cycles got %0d want 5", bc); end
        checks++; if (rd !== model_mem[5]) begin errors++; $display("FAIL hold_data got %h want %h", rd, model_mem[5]); end
        exp_md = model_mem[5];
        // memwrite dropped during WAIT.
        mar = 32'd30; wr_data = 32'hBAD0_0030; memwrite = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_in_wait busy %b want 1", busy); end
        memwrite = 1'b0;
        rc = 0; bc = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (mem_ready) rc++;
            if (busy) bc++;
        end
        checks++; if (rc !== 0) begin errors++; $display("FAIL abort_no_ready got %0d want 0", rc); end
        checks++; if (bc !== 0) begin errors++; $display("FAIL abort_back_idle busy %0d want 0", bc); end
        run_access(1'b0, 32'd30, 32'h0, 0, lat, rd, bc, ec, rc);
        checks++; if (rd !== 32'h3030_3030) begin errors++; $display("FAIL abort_ram_unchanged got %h want 30303030", rd); end
        exp_md = 32'h3030_3030;
    endtask

    task automatic test_illegal();
        int lat, bc, ec, rc;
        logic [31:0] rd;
        mar = 32'd20; memread = 1'b1; memwrite = 1'b1;
        @(posedge clk); #1;
        memread = 1'b0; memwrite = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL both_strobes_err got %b want 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL both_strobes_idle busy %b want 0", busy); end
        @(posedge clk); #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL both_strobes_pulse got %b want 0", err); end
        run_access(1'b0, 32'h0000_0200, 32'h0, 0, lat, rd, bc, ec, rc);
        checks++; if (ec !== 1) begin errors++; $display("FAIL oor_err_pulses got %0d want 1", ec); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_read_zero got %h want 0", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL oor_ready got %0d want 2", lat); end
        exp_md = 32'h0;
    endtask

    task automatic test_random();
        int lat, bc, ec, rc, hold;
        logic [31:0] rd, addr, data, want;
        bit is_wr, oor;
        for (int n = 0; n < 40; n++) begin
            is_wr = 1'($urandom_range(0, 1));
            oor   = ($urandom_range(0, 7) == 0);
            addr  = oor ? ($urandom() | 32'h0000_0200) : 32'(100 + $urandom_range(0, 15) * 7);
            data  = $urandom();
            hold  = $urandom_range(0, 2);
            want  = is_wr ? exp_md : (oor ? 32'h0 : model_mem[addr[8:0]]);
            run_access(is_wr, addr, data, hold, lat, rd, bc, ec, rc);
            checks++;
            if (lat !== 2 || rd !== want || rc !== hold + 1 || bc !== hold + 3 || ec !== (oor ? 1 : 0)) begin
                errors++;
                $display("FAIL random_%0d wr=%0b addr=%h got lat=%0d data=%h ready=%0d busy=%0d err=%0d want lat=2 data=%h ready=%0d busy=%0d err=%0d",
                         n, is_wr, addr, lat, rd, rc, bc, ec, want, hold + 1, hold + 3, oor ? 1 : 0);
            end
            exp_md = want;
            if (is_wr && !oor) model_mem[addr[8:0]] = data;
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, ec, rc;
        logic [31:0] rd;
        run_access(1'b0, 32'd341, 32'h0, 0, lat, rd, bc, ec, rc);
        mar = 32'd5; wr_data = 32'hFFFF_0005; memwrite = 1'b1;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy got %b want 0", busy); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL clear_ready got %b want 0", mem_ready); end
        checks++; if (mem_data !== 32'h0) begin errors++; $display("FAIL clear_mem_data got %h want 0", mem_data); end
        clear = 1'b0; memwrite = 1'b0;
        @(posedge clk); #1;
        run_access(1'b0, 32'd5, 32'h0, 0, lat, rd, bc, ec, rc);
        checks++; if (rd !== model_mem[5]) begin errors++; $display("FAIL clear_ram5_kept got %h want %h", rd, model_mem[5]); end
        run_access(1'b0, 32'd341, 32'h0, 0, lat, rd, bc, ec, rc);
        checks++; if (rd !== 32'h0A80_0004) begin errors++; $display("FAIL clear_ram341_kept got %h want 0a800004", rd); end
    endtask

    task automatic test_wait0();
        int lat;
        logic [31:0] rd;
        initMem0 = 1'b1; init_addr0 = 9'd341; init_data0 = 32'h0A80_0004;
        @(posedge clk); #1;
        initMem0 = 1'b0;
        lat = -1; rd = '0;
        mar0 = 32'd341; memread0 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (mem_ready0 && lat < 0) begin lat = k - 1; rd = mem_data0; memread0 = 1'b0; end
        end
        memread0 = 1'b0;
        checks++; if (lat !== 1) begin errors++; $display("FAIL wait0_latency got %0d want 1", lat); end
        checks++; if (rd !== 32'h0A80_0004) begin errors++; $display("FAIL wait0_data got %h want 0a800004", rd); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL wait0_idle busy %b want 0", busy0); end
    endtask

    initial begin
        clear = 1'b1; mar = '0; wr_data = '0; memread = 1'b0; memwrite = 1'b0;
        initMem = 1'b0; init_addr = '0; init_data = '0;
        mar0 = '0; wr_data0 = '0; memread0 = 1'b0; memwrite0 = 1'b0;
        initMem0 = 1'b0; init_addr0 = '0; init_data0 = '0;
        exp_md = '0;
        test_reset();
        test_preload();
        test_write_read();
        test_hold_abort();
        test_illegal();
        test_random();
        test_reset_mid();
        test_wait0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
